// File: rtl/amem_port.sv
// A-memory port: one registered read port and one write port on a single-clock array,
// with an optional post-reset sweep that zeroes every word before user traffic is accepted.
module amem_port #(
  parameter int ADDR_W         = 10,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] aadr,
  input  logic              arp,
  input  logic              awp,
  input  logic [DATA_W-1:0] l,
  output logic [DATA_W-1:0] a,
  output logic              init_busy
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic [DATA_W-1:0] a_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              busy;
  logic              user_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              rd_en;

  // pend_q arms exactly one sweep per reset; it is consumed when CLEAR is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_q  <= (CLEAR_ON_RESET != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = CLEAR;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state_q == CLEAR);
  assign user_en = !reset && !busy;

  // The sweep and the user share one write port; the sweep owns it while busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = aadr;
    mem_wdata = l;
    if (busy) begin
      mem_we    = !reset;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (user_en && awp) begin
      mem_we = 1'b1;
    end
  end

  assign rd_en = user_en && arp;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Write-first on a shared address: the incoming data bypasses the array.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
    end else if (rd_en) begin
      a_q <= awp ? l : mem[aadr];
    end
  end

  assign a         = a_q;
  assign init_busy = busy;

endmodule

// File: tb/tb_amem_port.sv
// Scoreboard bench for amem_port: expected read data is queued when a read is issued
// and popped when the registered output is sampled one edge later.
module tb_amem_port;

  logic        clk;
  logic        reset;
  logic [9:0]  aadr;
  logic        arp;
  logic        awp;
  logic [31:0] l;
  logic [31:0] a;
  logic        init_busy;

  int n_vec  = 0;
  int n_fail = 0;

  logic [31:0] model_mem [1024];
  logic [31:0] exp_q [$];

  amem_port #(.ADDR_W(10), .DATA_W(32), .CLEAR_ON_RESET(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .aadr      (aadr),
    .arp       (arp),
    .awp       (awp),
    .l         (l),
    .a         (a),
    .init_busy (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_model();
    for (int i = 0; i < 1024; i++) model_mem[i] = 32'h0;
  endtask

  task automatic issue_write(input logic [9:0] adr, input logic [31:0] dat);
    awp = 1'b1; aadr = adr; l = dat;
    model_mem[adr] = dat;
    cycle();
    awp = 1'b0;
  endtask

  task automatic issue_read(input logic [9:0] adr);
    arp = 1'b1; aadr = adr;
    exp_q.push_back(model_mem[adr]);
    cycle();
    arp = 1'b0;
  endtask

  // Runs until init_busy has been seen high and then low again, or the budget expires.
  task automatic wait_clear(input int already, output int busy_n, output bit timed_out);
    busy_n    = already;
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (init_busy === 1'b1) busy_n++;
      else if (busy_n > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int busy_n;
    bit to;
    logic [31:0] e;
    reset = 1'b1; arp = 1'b0; awp = 1'b0; aadr = '0; l = '0;
    cycle(); cycle();
    n_vec++;
    if (a !== 32'h0) begin n_fail++; $display("FAIL reset_a: got %h want %h", a, 32'h0); end
    n_vec++;
    if (init_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", init_busy); end
    reset = 1'b0;
    wait_clear(0, busy_n, to);
    n_vec++;
    if (to) begin n_fail++; $display("FAIL init_timeout: busy never dropped"); end
    n_vec++;
    if (busy_n != 1024) begin n_fail++; $display("FAIL init_len: got %0d want 1024", busy_n); end
    zero_model();
    issue_read(10'd0);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL init_rd0: got %h want %h", a, e); end
    issue_read(10'd513);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL init_rd513: got %h want %h", a, e); end
    issue_read(10'd1023);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL init_rd1023: got %h want %h", a, e); end
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    issue_write(10'h155, 32'hDEADBEEF);
    issue_read(10'h155);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL wr_rd: got %h want %h", a, e); end
    for (int i = 0; i < 3; i++) begin
      aadr = 10'(i * 37);
      cycle();
      n_vec++;
      if (a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL hold_%0d: got %h want %h", i, a, 32'hDEADBEEF); end
    end
  endtask

  task automatic test_write_first();
    logic [31:0] e;
    arp = 1'b1; awp = 1'b1; aadr = 10'h3FF; l = 32'h12345678;
    model_mem[10'h3FF] = 32'h12345678;
    exp_q.push_back(32'h12345678);
    cycle();
    arp = 1'b0; awp = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL wfirst_a: got %h want %h", a, e); end
    issue_read(10'h000);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL wfirst_other: got %h want %h", a, e); end
    issue_read(10'h3FF);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL wfirst_rd: got %h want %h", a, e); end
  endtask

  task automatic test_no_snoop();
    logic [31:0] e;
    logic [31:0] v;
    issue_write(10'h010, 32'h5A5A1234);
    issue_read(10'h010);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL snoop_rd: got %h want %h", a, e); end
    v = e;
    issue_write(10'h010, 32'hCAFEF00D);
    n_vec++;
    if (a !== v) begin n_fail++; $display("FAIL snoop_hold: got %h want %h", a, v); end
    issue_read(10'h010);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL snoop_new: got %h want %h", a, e); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [9:0]  adrs [8];
    for (int i = 0; i < 8; i++) begin
      adrs[i] = 10'(100 + i * 97);
      issue_write(adrs[i], $urandom());
    end
    arp = 1'b1;
    for (int i = 0; i < 8; i++) begin
      aadr = adrs[i];
      exp_q.push_back(model_mem[adrs[i]]);
      cycle();
      e = exp_q.pop_front(); n_vec++;
      if (a !== e) begin n_fail++; $display("FAIL b2b_%0d: got %h want %h", i, a, e); end
    end
    arp = 1'b0;
  endtask

  task automatic test_busy_ignore();
    int busy_n;
    bit to;
    logic [31:0] e;
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 400 && busy_n < 301; i++) begin
      cycle();
      if (init_busy === 1'b1) busy_n++;
    end
    n_vec++;
    if (busy_n != 301) begin n_fail++; $display("FAIL busy_reach300: got %0d want 301", busy_n); end
    arp = 1'b1; awp = 1'b1; aadr = 10'h005; l = 32'hFFFFFFFF;
    cycle();
    arp = 1'b0; awp = 1'b0;
    if (init_busy === 1'b1) busy_n++;
    n_vec++;
    if (a !== 32'h0) begin n_fail++; $display("FAIL busy_a: got %h want %h", a, 32'h0); end
    wait_clear(busy_n, busy_n, to);
    n_vec++;
    if (to || busy_n != 1024) begin n_fail++; $display("FAIL busy_len: got %0d want 1024", busy_n); end
    zero_model();
    issue_read(10'h005);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL busy_word5: got %h want %h", a, e); end
  endtask

  task automatic test_reset_mid_clear();
    int busy_n;
    bit to;
    logic [31:0] e;
    for (int i = 0; i < 16; i++) issue_write(10'($urandom_range(0, 1023)), $urandom() | 32'h1);
    issue_read(10'h3FF);
    e = exp_q.pop_front(); n_vec++;
    if (a !== e) begin n_fail++; $display("FAIL pre_rd: got %h want %h", a, e); end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    busy_n = 0;
    for (int i = 0; i < 800 && busy_n < 701; i++) begin
      cycle();
      if (init_busy === 1'b1) busy_n++;
    end
    n_vec++;
    if (busy_n != 701) begin n_fail++; $display("FAIL mid_reach700: got %0d want 701", busy_n); end
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_vec++;
      if (init_busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy_%0d: got %b want 0", i, init_busy); end
      n_vec++;
      if (a !== 32'h0) begin n_fail++; $display("FAIL mid_rst_a_%0d: got %h want 0", i, a); end
    end
    reset = 1'b0;
    wait_clear(0, busy_n, to);
    n_vec++;
    if (to || busy_n != 1024) begin n_fail++; $display("FAIL mid_len: got %0d want 1024", busy_n); end
    zero_model();
    arp = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      aadr = 10'(i);
      exp_q.push_back(model_mem[i]);
      cycle();
      e = exp_q.pop_front(); n_vec++;
      if (a !== e) begin n_fail++; $display("FAIL sweep_%0d: got %h want %h", i, a, e); end
    end
    arp = 1'b0;
  endtask

  initial begin
    reset = 1'b1; arp = 1'b0; awp = 1'b0; aadr = '0; l = '0;
    zero_model();
    test_reset();
    test_write_read();
    test_write_first();
    test_no_snoop();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/amem_port.md
AMEM_PORT -- requirements
Module: amem_port

Interface
REQ-001 Parameter ADDR_W, default 10, is the A-memory address width; depth is 2^ADDR_W words.
REQ-002 Parameter DATA_W, default 32, is the A-memory word width.
REQ-003 Parameter CLEAR_ON_RESET, default 1, enables the post-reset clear sequencer when 1.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 aadr  input  ADDR_W  A-memory address, used for both read and write cycles.
REQ-007 arp  input  1  read strobe; samples aadr on the edge where arp=1.
REQ-008 awp  input  1  write strobe; writes l to the word at aadr on the edge where awp=1.
REQ-009 l  input  DATA_W  write data.
REQ-010 a  output  DATA_W  registered read data.
REQ-011 init_busy  output  1  high while the clear sequencer owns the memory.

Function
REQ-012 The block SHALL hold a 2^ADDR_W x DATA_W storage array.
REQ-013 Read: arp=1 at edge N SHALL load a with word[aadr], valid from edge N through the next arp edge; a SHALL hold its value when arp=0.
REQ-014 Write: awp=1 at edge N SHALL update word[aadr] with l at edge N; a read issued at edge N+1 or later SHALL return the new value.
REQ-015 Simultaneous arp=1 and awp=1 at one edge (single shared aadr) SHALL be write-first: word[aadr] and a both take l.
REQ-016 A write to the address last read, without a new arp, SHALL NOT change a (no snooping).
REQ-017 Clear sequencer states: IDLE, CLEAR; a 1-bit state plus ADDR_W-bit clear counter.
REQ-018 With CLEAR_ON_RESET=1, the edge after reset deasserts SHALL enter CLEAR with counter 0; each CLEAR cycle SHALL write 0 to word[counter] and increment counter.
REQ-019 CLEAR SHALL exit to IDLE on the edge that writes word[2^ADDR_W-1]; counter wraps to 0 and does not repeat the sweep.
REQ-020 init_busy SHALL be 1 in CLEAR and 0 in IDLE; clearing 1024 words takes exactly 1024 cycles with init_busy=1.
REQ-021 While init_busy=1, arp and awp SHALL be ignored: no user writes, a unchanged.
REQ-022 With CLEAR_ON_RESET=0, the sequencer SHALL remain IDLE, init_busy SHALL stay 0, and array contents after reset are unspecified.
REQ-023 All address arithmetic SHALL be unsigned, modulo 2^ADDR_W; no out-of-range address exists.

Reset
REQ-024 While reset=1: a SHALL be 0, init_busy SHALL be 0, state IDLE, counter 0, no array writes from arp/awp.
REQ-025 Reset asserted during CLEAR SHALL abort the sweep; after deassertion the sweep SHALL restart at word 0.
REQ-026 Reset SHALL NOT itself clear the array; clearing is performed only by the sequencer.

Verification
REQ-027 Reset 1 cycle then release -> init_busy=1 for exactly 1024 cycles, then 0; read of addresses 0, 513, 1023 returns 0.
REQ-028 After init: awp, aadr=0x155, l=0xDEADBEEF; next cycle arp, aadr=0x155 -> a=0xDEADBEEF one edge later, held while arp=0.
REQ-029 arp=1 and awp=1 same edge, aadr=0x3FF, l=0x12345678 -> a=0x12345678; subsequent read of 0x3FF returns 0x12345678.
REQ-030 Read 0x010 (a=V), then write 0x010 with 0xCAFEF00D and arp=0 -> a stays V; next arp -> a=0xCAFEF00D.
REQ-031 During CLEAR at counter 300, issue awp to 0x005 with 0xFFFFFFFF and arp to 0x005 -> a unchanged, word[5] reads 0 after init.
REQ-032 Assert reset at counter 700 for 2 cycles after writing random data pre-reset -> init_busy low during reset, then high 1024 cycles; all 1024 words read 0.
